readback_snapshot_sync: RTL and testbench
=========================================

# readback_snapshot_sync

Request/acknowledge front end for the GPIO readback multiplexer. It takes a readback address and a request toggle from the PS GPIO and drives `config_addr` to the multiplexer. After a settle interval it captures the multiplexer's A/B words into hold registers and toggles an acknowledge. The PS therefore always reads a coherent A/B pair belonging to the address it requested. Between requests it parks `config_addr` on an idle address, so address-triggered side effects in the multiplexer fire exactly once per request.

## Interface
- `SETTLE_CYCLES`, default 4: clock edges from address load to capture. Values below 2 are treated as 2; 8-bit range.
- `IDLE_ADDR`, default 0: address driven while idle. Must decode to the multiplexer's default case.
- `RETURN_TO_IDLE`, default 1: 1 = park on `IDLE_ADDR` after each capture; 0 = hold the last requested address.
- `aclk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `ps_addr` in 32: requested readback address from PS GPIO. Must be held stable until `ps_ack` toggles.
- `ps_req` in 1: request toggle from PS GPIO. Each level change is one request.
- `config_addr` out 32: address to the readback multiplexer.
- `rb_dataA` in 32: multiplexer output A (registered, 1-cycle latency).
- `rb_dataB` in 32: multiplexer output B.
- `snap_dataA` out 32: captured A word to PS GPIO.
- `snap_dataB` out 32: captured B word to PS GPIO.
- `ps_ack` out 1: acknowledge toggle. Equals the synchronized `ps_req` level once the snapshot is valid.
- `snap_seq` out 16: completed-snapshot counter, wraps.
- `busy` out 1: high from address load until capture.

## Operation
- `ps_req` passes through a 2-flop synchronizer (`req_s`). A request is pending whenever `req_s != ps_ack`. No edge detector is used.
- FSM states: IDLE, SETTLE.
- IDLE:
  - drives `config_addr = RETURN_TO_IDLE ? IDLE_ADDR : last_addr`
  - on a pending request: latch `ps_addr` into `last_addr`, set `config_addr <= ps_addr`, set `req_lat <= req_s`, load counter = eff_settle-1, set `busy`, go to SETTLE.
- SETTLE:
  - decrement the counter each edge.
  - When the counter is 0: capture `snap_dataA/B <= rb_dataA/B`, set `ps_ack <= req_lat`, increment `snap_seq` (0xFFFF -> 0x0000), clear `busy`, apply the idle `config_addr`, go to IDLE.
- IDLE always lasts at least one cycle. With `RETURN_TO_IDLE=1` the multiplexer therefore registers `IDLE_ADDR` at least once between consecutive requests.
- Toggles of `ps_req` during SETTLE are not lost. They are evaluated in IDLE by level comparison.
  - An odd number of toggles during busy produces one further request.
  - An even number produces none; this is by design.
- `ps_addr` is sampled only on the IDLE->SETTLE transition. Changes during SETTLE are ignored.
- `snap_dataA/B` change only at capture, never mid-transaction.
- `eff_settle = max(SETTLE_CYCLES, 2)`.

## Timing
- Reset values:
  - `config_addr = IDLE_ADDR`
  - `snap_dataA/B = 0`, `ps_ack = 0`, `snap_seq = 0`, `busy = 0`
  - synchronizer flops = 0, state = IDLE.
- Let `ps_req` change between edges 0 and 1.
  - `req_s` is valid after edge 2.
  - Load happens at edge 3: `config_addr` = the request address and `busy` = 1.
  - The multiplexer registers the new address at edge 4.
  - Capture happens at edge 3+eff_settle. At that edge `snap_dataA/B`, `ps_ack` and `snap_seq` all update and `busy` falls.
- Request-to-ack latency is 3+eff_settle edges; 7 with the defaults.
- Back-to-back requests: the next load is no earlier than capture edge + 1.
- Reset asserted mid-SETTLE:
  - all outputs return immediately (asynchronously) to their reset values and the transaction is discarded.
  - If `ps_req = 1` at reset release, a request is started 3 edges after release.
- Sustained throughput is one snapshot per eff_settle+1 cycles.

## Test plan
- **Basic read.** Mock multiplexer with A = addr+1, B = ~addr. Set `ps_addr = 100002` and toggle `ps_req` 0->1.
  - `config_addr = 100002` at edge 3.
  - `ps_ack = 1`, `snap_dataA = 100003`, `snap_dataB = ~100002`, `snap_seq = 1` and `busy = 0` at edge 7.
  - `config_addr = 0` from edge 7.
- **Toggle during busy.** Toggle `ps_req` again at edge 4 with `ps_addr = 100005`.
  - The first ack comes at edge 7.
  - The second load comes at edge 8 with `config_addr = 100005`.
  - The second ack (0) comes at edge 12, with `snap_seq = 2`.
- **Double toggle during SETTLE.** Toggle twice inside SETTLE -> exactly one ack; `snap_seq = 1`; no second load.
- **Reset mid-SETTLE.** Assert `reset` at edge 5 of a transaction.
  - Outputs are immediately 0 / `IDLE_ADDR`.
  - With `ps_req = 1` held, a new load occurs 3 edges after release and the ack follows 4 edges later.
- **Parameter corners.**
  - `SETTLE_CYCLES = 0` -> ack at edge 5.
  - `RETURN_TO_IDLE = 0` -> `config_addr` holds 100002 after capture.
- **Counter wrap.** Preload by running 65536 requests -> `snap_seq` wraps to 0x0000 and `ps_ack` parity stays consistent.

Source files
------------

// File: rtl/readback_snapshot_sync.sv
// rtl/readback_snapshot_sync.sv - request/ack front end that snapshots readback mux A/B words
module readback_snapshot_sync #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter logic [31:0] IDLE_ADDR      = 32'd0,
  parameter bit          RETURN_TO_IDLE = 1'b1
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [31:0] ps_addr,
  input  logic        ps_req,
  output logic [31:0] config_addr,
  input  logic [31:0] rb_dataA,
  input  logic [31:0] rb_dataB,
  output logic [31:0] snap_dataA,
  output logic [31:0] snap_dataB,
  output logic        ps_ack,
  output logic [15:0] snap_seq,
  output logic        busy
);

  localparam int unsigned EFF_SETTLE = (SETTLE_CYCLES < 2) ? 2 : SETTLE_CYCLES;
  localparam logic [7:0]  CNT_LOAD   = 8'(EFF_SETTLE - 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t      state;
  logic        req_m;
  logic        req_s;
  logic        req_lat;
  logic [7:0]  cnt;
  logic [31:0] last_addr;
  logic [31:0] idle_addr;

  assign idle_addr = RETURN_TO_IDLE ? IDLE_ADDR : last_addr;

  // Pending is a level compare (req_s vs ps_ack), so toggles that land while
  // busy collapse by parity and are picked up on the next IDLE cycle.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_m       <= 1'b0;
      req_s       <= 1'b0;
      req_lat     <= 1'b0;
      cnt         <= 8'd0;
      last_addr   <= IDLE_ADDR;
      config_addr <= IDLE_ADDR;
      snap_dataA  <= 32'd0;
      snap_dataB  <= 32'd0;
      ps_ack      <= 1'b0;
      snap_seq    <= 16'd0;
      busy        <= 1'b0;
    end else begin
      req_m <= ps_req;
      req_s <= req_m;
      case (state)
        IDLE: begin
          if (req_s != ps_ack) begin
            last_addr   <= ps_addr;
            config_addr <= ps_addr;
            req_lat     <= req_s;
            cnt         <= CNT_LOAD;
            busy        <= 1'b1;
            state       <= SETTLE;
          end else begin
            config_addr <= idle_addr;
          end
        end
        SETTLE: begin
          if (cnt == 8'd0) begin
            snap_dataA  <= rb_dataA;
            snap_dataB  <= rb_dataB;
            ps_ack      <= req_lat;
            snap_seq    <= snap_seq + 16'd1;
            busy        <= 1'b0;
            config_addr <= idle_addr;
            state       <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readback_snapshot_sync.sv
// tb/tb_readback_snapshot_sync.sv - directed bench for readback_snapshot_sync
module tb_readback_snapshot_sync;

  logic        aclk = 1'b0;
  logic        reset;
  logic [31:0] ps_addr;
  logic        ps_req;

  // d0: defaults, s0: SETTLE_CYCLES=0, r0: RETURN_TO_IDLE=0
  logic [31:0] cfg_d0, cfg_s0, cfg_r0;
  logic [31:0] rba_d0, rba_s0, rba_r0, rbb_d0, rbb_s0, rbb_r0;
  logic [31:0] sa_d0, sa_s0, sa_r0, sb_d0, sb_s0, sb_r0;
  logic        ack_d0, ack_s0, ack_r0;
  logic [15:0] seq_d0, seq_s0, seq_r0;
  logic        busy_d0, busy_s0, busy_r0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  readback_snapshot_sync dut (
    .aclk(aclk), .reset(reset), .ps_addr(ps_addr), .ps_req(ps_req),
    .config_addr(cfg_d0), .rb_dataA(rba_d0), .rb_dataB(rbb_d0),
    .snap_dataA(sa_d0), .snap_dataB(sb_d0), .ps_ack(ack_d0),
    .snap_seq(seq_d0), .busy(busy_d0)
  );

  readback_snapshot_sync #(.SETTLE_CYCLES(0)) dut_s0 (
    .aclk(aclk), .reset(reset), .ps_addr(ps_addr), .ps_req(ps_req),
    .config_addr(cfg_s0), .rb_dataA(rba_s0), .rb_dataB(rbb_s0),
    .snap_dataA(sa_s0), .snap_dataB(sb_s0), .ps_ack(ack_s0),
    .snap_seq(seq_s0), .busy(busy_s0)
  );

  readback_snapshot_sync #(.RETURN_TO_IDLE(0)) dut_r0 (
    .aclk(aclk), .reset(reset), .ps_addr(ps_addr), .ps_req(ps_req),
    .config_addr(cfg_r0), .rb_dataA(rba_r0), .rb_dataB(rbb_r0),
    .snap_dataA(sa_r0), .snap_dataB(sb_r0), .ps_ack(ack_r0),
    .snap_seq(seq_r0), .busy(busy_r0)
  );

  // Mock multiplexers: registered, A = addr+1, B = ~addr
  always_ff @(posedge aclk) begin
    rba_d0 <= cfg_d0 + 32'd1; rbb_d0 <= ~cfg_d0;
    rba_s0 <= cfg_s0 + 32'd1; rbb_s0 <= ~cfg_s0;
    rba_r0 <= cfg_r0 + 32'd1; rbb_r0 <= ~cfg_r0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge aclk);
    @(negedge aclk);
  endtask

  initial begin
    reset   = 1'b1;
    ps_addr = 32'd0;
    ps_req  = 1'b0;
    adv(2);
    check("rst_cfg_d0",  cfg_d0,  32'd0);
    check("rst_ack_d0",  {31'd0, ack_d0},  32'd0);
    check("rst_seq_d0",  {16'd0, seq_d0},  32'd0);
    check("rst_busy_d0", {31'd0, busy_d0}, 32'd0);
    check("rst_sa_d0",   sa_d0,   32'd0);
    check("rst_sb_d0",   sb_d0,   32'd0);
    check("rst_cfg_r0",  cfg_r0,  32'd0);
    reset = 1'b0;
    adv(3);

    // Basic read: request changes between edge 0 and edge 1
    ps_addr = 32'd100002;
    ps_req  = 1'b1;
    adv(2);
    check("a_e2_busy", {31'd0, busy_d0}, 32'd0);
    check("a_e2_cfg",  cfg_d0, 32'd0);
    adv(1);
    check("a_e3_cfg",    cfg_d0, 32'd100002);
    check("a_e3_busy",   {31'd0, busy_d0}, 32'd1);
    check("a_e3_cfg_s0", cfg_s0, 32'd100002);
    adv(1);
    check("a_e4_ack_s0", {31'd0, ack_s0}, 32'd0);
    adv(1);
    check("a_e5_ack_s0",  {31'd0, ack_s0}, 32'd1);
    check("a_e5_sa_s0",   sa_s0,  32'd100003);
    check("a_e5_busy_s0", {31'd0, busy_s0}, 32'd0);
    check("a_e5_cfg_s0",  cfg_s0, 32'd0);
    check("a_e5_ack_d0",  {31'd0, ack_d0}, 32'd0);
    adv(1);
    check("a_e6_busy", {31'd0, busy_d0}, 32'd1);
    check("a_e6_sa",   sa_d0, 32'd0);
    adv(1);
    check("a_e7_ack",    {31'd0, ack_d0}, 32'd1);
    check("a_e7_sa",     sa_d0,  32'd100003);
    check("a_e7_sb",     sb_d0,  ~32'd100002);
    check("a_e7_seq",    {16'd0, seq_d0}, 32'd1);
    check("a_e7_busy",   {31'd0, busy_d0}, 32'd0);
    check("a_e7_cfg",    cfg_d0, 32'd0);
    check("a_e7_cfg_r0", cfg_r0, 32'd100002);
    check("a_e7_ack_r0", {31'd0, ack_r0}, 32'd1);
    adv(1);
    check("a_e8_busy",   {31'd0, busy_d0}, 32'd0);
    check("a_e8_cfg",    cfg_d0, 32'd0);
    check("a_e8_cfg_r0", cfg_r0, 32'd100002);
    adv(2);

    // Toggle during busy: second request queued by level, loads at edge 8
    ps_addr = 32'd100004;
    ps_req  = 1'b0;
    adv(4);
    ps_addr = 32'd100005;
    ps_req  = 1'b1;
    adv(3);
    check("b_e7_ack", {31'd0, ack_d0}, 32'd0);
    check("b_e7_seq", {16'd0, seq_d0}, 32'd2);
    check("b_e7_sa",  sa_d0, 32'd100005);
    check("b_e7_cfg", cfg_d0, 32'd0);
    adv(1);
    check("b_e8_cfg",  cfg_d0, 32'd100005);
    check("b_e8_busy", {31'd0, busy_d0}, 32'd1);
    adv(3);
    check("b_e11_ack", {31'd0, ack_d0}, 32'd0);
    adv(1);
    check("b_e12_ack", {31'd0, ack_d0}, 32'd1);
    check("b_e12_seq", {16'd0, seq_d0}, 32'd3);
    check("b_e12_sa",  sa_d0, 32'd100006);
    check("b_e12_sb",  sb_d0, ~32'd100005);
    adv(3);

    // Double toggle inside SETTLE: one ack, no second load
    ps_addr = 32'd100010;
    ps_req  = 1'b0;
    adv(4);
    ps_req = 1'b1;
    adv(1);
    ps_req = 1'b0;
    adv(2);
    check("c_e7_ack", {31'd0, ack_d0}, 32'd0);
    check("c_e7_seq", {16'd0, seq_d0}, 32'd4);
    check("c_e7_sa",  sa_d0, 32'd100011);
    adv(1);
    check("c_e8_busy", {31'd0, busy_d0}, 32'd0);
    check("c_e8_cfg",  cfg_d0, 32'd0);
    adv(3);
    check("c_e11_busy", {31'd0, busy_d0}, 32'd0);
    check("c_e11_seq",  {16'd0, seq_d0}, 32'd4);
    adv(3);

    // Reset mid-SETTLE with ps_req held high afterwards
    ps_addr = 32'd100020;
    ps_req  = 1'b1;
    adv(5);
    check("d_e5_busy", {31'd0, busy_d0}, 32'd1);
    reset = 1'b1;
    #1;
    check("d_rst_cfg",  cfg_d0, 32'd0);
    check("d_rst_busy", {31'd0, busy_d0}, 32'd0);
    check("d_rst_ack",  {31'd0, ack_d0}, 32'd0);
    check("d_rst_seq",  {16'd0, seq_d0}, 32'd0);
    check("d_rst_sa",   sa_d0, 32'd0);
    check("d_rst_sb",   sb_d0, 32'd0);
    check("d_rst_cfg_r0", cfg_r0, 32'd0);
    @(negedge aclk);
    reset = 1'b0;
    adv(2);
    check("d_r2_busy", {31'd0, busy_d0}, 32'd0);
    adv(1);
    check("d_r3_busy",   {31'd0, busy_d0}, 32'd1);
    check("d_r3_cfg",    cfg_d0, 32'd100020);
    check("d_r3_cfg_s0", cfg_s0, 32'd100020);
    adv(1);
    check("d_r4_ack_s0", {31'd0, ack_s0}, 32'd0);
    adv(1);
    check("d_r5_ack_s0", {31'd0, ack_s0}, 32'd1);
    check("d_r5_seq_s0", {16'd0, seq_s0}, 32'd1);
    check("d_r5_sa_s0",  sa_s0, 32'd100021);
    adv(1);
    check("d_r6_ack", {31'd0, ack_d0}, 32'd0);
    adv(1);
    check("d_r7_ack",    {31'd0, ack_d0}, 32'd1);
    check("d_r7_seq",    {16'd0, seq_d0}, 32'd1);
    check("d_r7_sa",     sa_d0, 32'd100021);
    check("d_r7_cfg",    cfg_d0, 32'd0);
    check("d_r7_cfg_r0", cfg_r0, 32'd100020);
    adv(2);
    check("d_r9_cfg_r0", cfg_r0, 32'd100020);
    check("d_r9_busy",   {31'd0, busy_d0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
